// File: rtl/param_frame_tx.sv
// param_frame_tx
// Sends a captured parameter block as one frame on a valid/ready word stream:
//   SOF marker, length (NUM_WORDS), NUM_WORDS payload words, checksum.
// Checksum = (NUM_WORDS + sum of payload words) mod 2**DATA_W.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   frame request, honoured only while idle
//   words_in  in   NUM_WORDS*DATA_W payload, word k at [k*DATA_W +: DATA_W]
//   tx_data   out  stream word (registered)
//   tx_valid  out  stream valid (registered)
//   tx_ready  in   sink accepts the word
//   busy      out  frame in progress (registered)
//   done      out  one-cycle pulse after the checksum beat is accepted
module param_frame_tx #(
  parameter int unsigned          DATA_W    = 8,
  parameter int unsigned          NUM_WORDS = 4,
  parameter logic [DATA_W-1:0]    SOF       = DATA_W'(8'hA5)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_WORDS*DATA_W-1:0]   words_in,
  output logic [DATA_W-1:0]             tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [DATA_W-1:0] LEN_WORD = DATA_W'(NUM_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_LEN,
    S_DATA,
    S_CSUM
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic [DATA_W-1:0]   shadow_q [NUM_WORDS];
  logic [DATA_W-1:0]   shadow_d [NUM_WORDS];
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;

  assign accept = tx_valid_q && tx_ready;

  // The word for the next beat is loaded into tx_data_q on the accepting
  // edge, so every output stays a plain flop and valid never looks at ready.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    shadow_d   = shadow_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            shadow_d[k] = words_in[k*DATA_W +: DATA_W];
          end
          idx_d      = '0;
          csum_d     = LEN_WORD;
          tx_data_d  = SOF;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_SOF;
        end
      end

      S_SOF: begin
        if (accept) begin
          tx_data_d = LEN_WORD;
          state_d   = S_LEN;
        end
      end

      S_LEN: begin
        if (accept) begin
          tx_data_d = shadow_q[idx_q];
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (accept) begin
          // tx_data_q holds shadow[idx], i.e. the word just accepted
          csum_d = csum_q + tx_data_q;
          if (idx_q == LAST_IDX) begin
            tx_data_d = csum_d;
            state_d   = S_CSUM;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = shadow_q[idx_d];
          end
        end
      end

      S_CSUM: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Shadow register deliberately has no reset value: it is only written on
  // capture, so it keeps its contents through rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      csum_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      shadow_q   <= shadow_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_param_frame_tx.sv
// Self-checking bench for param_frame_tx: default instance (8-bit, 4 words)
// plus a single-word instance for the NUM_WORDS=1 boundary.
module tb_param_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] words_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic        start1;
  logic [7:0]  words_in1;
  logic [7:0]  tx_data1;
  logic        tx_valid1;
  logic        tx_ready1;
  logic        busy1;
  logic        done1;

  always #5 clk = ~clk;

  param_frame_tx dut (
    .clk(clk), .rst(rst), .start(start), .words_in(words_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  param_frame_tx #(.NUM_WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .words_in(words_in1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .busy(busy1), .done(done1)
  );

  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;
  int          rdy_phase = 0;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic [7:0]  got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: frame is SOF, length, payload in order, checksum.
  function automatic logic [7:0] exp_beat(input logic [31:0] w, input logic [7:0] cs, input int k);
    logic [31:0] ww;
    ww = w;
    if (k == 0) return 8'hA5;
    if (k == 1) return 8'd4;
    if (k <= 5) return ww[(k-2)*8 +: 8];
    return cs;
  endfunction

  function automatic logic [7:0] model_csum(input logic [31:0] w);
    int s;
    logic [31:0] ww;
    ww = w;
    s = 4;
    for (int i = 0; i < 4; i++) s += int'(ww[i*8 +: 8]);
    return 8'(s % 256);
  endfunction

  // Sink ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  initial begin
    tx_ready  = 1'b1;
    tx_ready1 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: begin
          tx_ready  = (rdy_phase == 0);
          rdy_phase = (rdy_phase + 1) % 3;
        end
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stream monitor: records accepted beats and checks the stall rule.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, tx_valid}, 32'd1);
        chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Called at #1 after an edge while idle; returns in the SOF cycle.
  task automatic start_frame(input logic [31:0] w);
    got.delete();
    words_in = w;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    words_in = $urandom;
    chk("sof_valid", {31'd0, tx_valid}, 32'd1);
    chk("sof_busy", {31'd0, busy}, 32'd1);
    chk("sof_data", {24'd0, tx_data}, 32'hA5);
  endtask

  task automatic finish_frame(input logic [31:0] w, input logic [7:0] cs, input bit full,
                              input bit mid, input bit b2b, input logic [31:0] w2);
    int cyc;
    int bcnt;
    cyc = 0;
    bcnt = 1;
    while (done !== 1'b1 && cyc < 200) begin
      start = (mid && cyc == 2);
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcnt++;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_valid", {31'd0, tx_valid}, 32'd0);
    if (full) chk("busy_cycles", bcnt, 32'd7);
    chk("beat_count", got.size(), 32'd7);
    for (int k = 0; k < got.size() && k < 7; k++)
      chk($sformatf("beat%0d", k), {24'd0, got[k]}, {24'd0, exp_beat(w, cs, k)});
    if (b2b) begin
      got.delete();
      words_in = w2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      words_in = $urandom;
      chk("b2b_valid", {31'd0, tx_valid}, 32'd1);
      chk("b2b_data", {24'd0, tx_data}, 32'hA5);
      chk("b2b_done_low", {31'd0, done}, 32'd0);
    end else begin
      @(posedge clk);
      #1;
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] words;
    logic [7:0]  csum;
    int          mode;
    bit          mid;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] w;
    logic [7:0]  b1exp [4];
    int          mode;

    vecs[0] = '{32'h04030201, 8'h0E, 0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 8'h00, 0, 1'b0};
    vecs[2] = '{32'h04030201, 8'h0E, 1, 1'b0};
    vecs[3] = '{32'h11223344, 8'hAE, 2, 1'b1};
    vecs[4] = '{32'h00000000, 8'h04, 1, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    words_in = '0;
    words_in1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_valid1", {31'd0, tx_valid1}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rdy_mode = vecs[i].mode;
      start_frame(vecs[i].words);
      finish_frame(vecs[i].words, vecs[i].csum, vecs[i].mode == 0, vecs[i].mid, 1'b0, '0);
    end

    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      mode = $urandom_range(0, 2);
      rdy_mode = mode;
      start_frame(w);
      finish_frame(w, model_csum(w), mode == 0, 1'($urandom_range(0, 1)), 1'b0, '0);
    end

    // Back-to-back: second start issued in the done cycle.
    rdy_mode = 0;
    start_frame(32'hDEADBEEF);
    finish_frame(32'hDEADBEEF, model_csum(32'hDEADBEEF), 1'b1, 1'b0, 1'b1, 32'h0BADF00D);
    finish_frame(32'h0BADF00D, model_csum(32'h0BADF00D), 1'b1, 1'b0, 1'b0, '0);

    // Reset while sending payload word 1.
    start_frame(32'h44332211);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_data1", {24'd0, tx_data}, 32'h22);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    mon_en = 1'b1;
    start_frame(32'h5A6B7C8D);
    finish_frame(32'h5A6B7C8D, model_csum(32'h5A6B7C8D), 1'b1, 1'b0, 1'b0, '0);

    // Single-word boundary instance.
    b1exp[0] = 8'hA5;
    b1exp[1] = 8'h01;
    b1exp[2] = 8'h7F;
    b1exp[3] = 8'h80;
    words_in1 = 8'h7F;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    words_in1 = 8'h00;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("n1_valid%0d", k), {31'd0, tx_valid1}, 32'd1);
      chk($sformatf("n1_beat%0d", k), {24'd0, tx_data1}, {24'd0, b1exp[k]});
      @(posedge clk);
      #1;
    end
    chk("n1_done", {31'd0, done1}, 32'd1);
    chk("n1_busy", {31'd0, busy1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
